arith_result_serializer: RTL and testbench

ARITH_RESULT_SERIALIZER -- requirements
Module: arith_result_serializer

---
 rtl/arith_pkg.sv | 35 +++
 rtl/arith_result_fifo.sv | 62 ++++++
 rtl/arith_result_serializer.sv | 150 +++++++++++++++
 tb/tb_arith_result_serializer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Brief    : Shared FSM state type and frame constants for the result
//            serializer. ARITH_SER_PARITY_EN adds the PAR state.
// Revision : 1.0
// ============================================================================
package arith_pkg;

`ifdef ARITH_SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_t;
    localparam int c_PAR_BYTES = 1;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;
    localparam int c_PAR_BYTES = 0;
`endif

    localparam logic [6:0] c_HDR_PATTERN = 7'h55;
    localparam int         c_HDR_BYTES   = 1;

    function automatic int data_bytes(input int width);
        return width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arith_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arith_result_fifo
// Brief    : Synchronous FIFO; a push while full is accepted only together
//            with a pop in the same cycle.
// Revision : 1.0
// ============================================================================
module arith_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int           c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rd_data   = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/arith_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : arith_result_serializer
// Brief    : Buffers {carry, result} words and streams them as byte frames
//            (header, data MSB first, optional parity via ARITH_SER_PARITY_EN).
// Revision : 1.0
// ============================================================================
module arith_result_serializer
    import arith_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 2 * IN_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                      Arith_Flag,
    input  logic                      Carry_OUT,
    output logic [7:0]                TX_DATA,
    output logic                      TX_VALID,
    input  logic                      TX_READY,
    output logic                      Busy,
    output logic                      Drop_ERR
);

    localparam int                c_DATA_BYTES = data_bytes(OUT_DATA_WIDTH);
    localparam int                c_IDX_W      = $clog2(c_DATA_BYTES + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_DATA_BYTES - 1);

    if (((OUT_DATA_WIDTH % 8) != 0) || (OUT_DATA_WIDTH < IN_DATA_WIDTH)) begin : g_bad_width
        $error("arith_result_serializer: OUT_DATA_WIDTH must be a multiple of 8 and >= IN_DATA_WIDTH");
    end

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_frame_done;
    logic [OUT_DATA_WIDTH:0]   w_rd_entry;
    logic                      r_carry;
    logic [OUT_DATA_WIDTH-1:0] r_shift;
    logic [c_IDX_W-1:0]        r_idx;
    logic                      r_drop;
`ifdef ARITH_SER_PARITY_EN
    logic [7:0]                r_parity;
`endif

    arith_result_fifo #(
        .WIDTH (OUT_DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (Arith_Flag),
        .pop     (w_pop),
        .wr_data ({Carry_OUT, Arith_OUT}),
        .rd_data (w_rd_entry),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;
        TX_VALID     = 1'b0;
        TX_DATA      = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_next = ST_HDR;
                    w_pop  = 1'b1;
                end
            end
            ST_HDR: begin
                TX_VALID = 1'b1;
                TX_DATA  = {r_carry, c_HDR_PATTERN};
                if (TX_READY) w_next = ST_DATA;
            end
            ST_DATA: begin
                TX_VALID = 1'b1;
                TX_DATA  = r_shift[OUT_DATA_WIDTH-1 -: 8];
                if (TX_READY && (r_idx == c_LAST_IDX)) begin
`ifdef ARITH_SER_PARITY_EN
                    w_next = ST_PAR;
`else
                    w_frame_done = 1'b1;
`endif
                end
            end
`ifdef ARITH_SER_PARITY_EN
            ST_PAR: begin
                TX_VALID = 1'b1;
                TX_DATA  = r_parity;
                if (TX_READY) w_frame_done = 1'b1;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
        // Chaining straight into the next header keeps back-to-back frames gapless.
        if (w_frame_done) begin
            if (!w_empty) begin
                w_next = ST_HDR;
                w_pop  = 1'b1;
            end else begin
                w_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_carry  <= 1'b0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_drop   <= 1'b0;
`ifdef ARITH_SER_PARITY_EN
            r_parity <= 8'h00;
`endif
        end else begin
            r_drop <= Arith_Flag && w_full && !w_pop;
            if (w_pop) begin
                r_carry  <= w_rd_entry[OUT_DATA_WIDTH];
                r_shift  <= w_rd_entry[OUT_DATA_WIDTH-1:0];
                r_idx    <= '0;
`ifdef ARITH_SER_PARITY_EN
                r_parity <= {w_rd_entry[OUT_DATA_WIDTH], c_HDR_PATTERN};
`endif
            end else if ((r_state == ST_DATA) && TX_READY) begin
                r_shift  <= r_shift << 8;
                r_idx    <= r_idx + 1'b1;
`ifdef ARITH_SER_PARITY_EN
                r_parity <= r_parity ^ r_shift[OUT_DATA_WIDTH-1 -: 8];
`endif
            end
        end
    end

    assign Busy     = (r_state != ST_IDLE) || !w_empty;
    assign Drop_ERR = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_arith_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_result_serializer
// Brief    : Directed-vector scoreboard bench for arith_result_serializer;
//            honours ARITH_SER_PARITY_EN for the expected parity bytes.
// Revision : 1.0
// ============================================================================
module tb_arith_result_serializer;

    logic        CLK;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Arith_Flag;
    logic        Carry_OUT;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        Busy;
    logic        Drop_ERR;

    logic [7:0] r_exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

`ifdef ARITH_SER_PARITY_EN
    localparam int c_B2B_BYTES = 18;
`else
    localparam int c_B2B_BYTES = 15;
`endif
    logic [7:0] c_ov_par [5] = '{8'hF4, 8'hF7, 8'hF6, 8'hF1, 8'hF0};

    arith_result_serializer #(
        .IN_DATA_WIDTH  (16),
        .OUT_DATA_WIDTH (32),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Arith_Flag (Arith_Flag),
        .Carry_OUT  (Carry_OUT),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .Busy       (Busy),
        .Drop_ERR   (Drop_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A byte seen valid+ready at the falling edge transfers on the next rising edge.
    always @(negedge CLK) begin
        if (!RST && TX_VALID && TX_READY) begin
            n_vec++;
            if (r_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream: unexpected byte %02h, none expected", TX_DATA);
            end else begin
                logic [7:0] v_exp;
                v_exp = r_exp_q.pop_front();
                if (TX_DATA !== v_exp) begin
                    n_err++;
                    $display("FAIL stream: got %02h expected %02h", TX_DATA, v_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [31:0] d, input logic [7:0] par);
        r_exp_q.push_back(hdr);
        r_exp_q.push_back(d[31:24]);
        r_exp_q.push_back(d[23:16]);
        r_exp_q.push_back(d[15:8]);
        r_exp_q.push_back(d[7:0]);
`ifdef ARITH_SER_PARITY_EN
        r_exp_q.push_back(par);
`endif
    endtask

    task automatic send(input logic [31:0] d, input logic c);
        Arith_OUT  = d;
        Carry_OUT  = c;
        Arith_Flag = 1'b1;
        @(posedge CLK);
        #1;
        Arith_Flag = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((r_exp_q.size() != 0 || TX_VALID) && t < 300) begin
            @(posedge CLK);
            #1;
            t++;
        end
        n_vec++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s: drain timeout, %0d bytes outstanding, required 0", name, r_exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int rises;
        int found;
        int seen;
        logic prev;

        RST        = 1'b1;
        Arith_OUT  = '0;
        Arith_Flag = 1'b0;
        Carry_OUT  = 1'b0;
        TX_READY   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", TX_VALID, 0);
        chk("rst_data",  TX_DATA,  0);
        chk("rst_busy",  Busy,     0);
        chk("rst_drop",  Drop_ERR, 0);
        RST = 1'b0;
        TX_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Single result and first-byte latency
        push_frame(8'h55, 32'h12345678, 8'h5D);
        send(32'h12345678, 1'b0);
        chk("lat_k1_valid", TX_VALID, 0);
        @(posedge CLK);
        #1;
        chk("lat_k2_valid", TX_VALID, 1);
        chk("lat_k2_hdr",   TX_DATA,  8'h55);
        chk("lat_k2_busy",  Busy,     1);
        wait_drain("single");
        chk("single_idle_busy", Busy, 0);

        // Backpressure on the second data byte
        push_frame(8'h55, 32'h12345678, 8'h5D);
        send(32'h12345678, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge CLK);
            #1;
            if (TX_VALID && TX_DATA == 8'h34) found = 1;
        end
        TX_READY = 1'b0;
        chk("bp_found", found, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("bp_hold", {TX_VALID, TX_DATA}, {1'b1, 8'h34});
        end
        TX_READY = 1'b1;
        wait_drain("backpressure");

        // Overflow: six results against a stalled sink
        TX_READY = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_frame(8'h55, 32'h000000A0 + k, c_ov_par[k-1]);
        end
        for (int k = 1; k <= 6; k++) begin
            send(32'h000000A0 + k, 1'b0);
            chk("ovf_drop", Drop_ERR, (k == 6) ? 1 : 0);
        end
        @(posedge CLK);
        #1;
        chk("ovf_drop_end", Drop_ERR, 0);
        chk("ovf_busy",     Busy,     1);
        TX_READY = 1'b1;
        wait_drain("overflow");

        // Back-to-back frames must be contiguous
        push_frame(8'h55, 32'h01020304, 8'h51);
        push_frame(8'hD5, 32'hA0B0C0D0, 8'hD5);
        push_frame(8'h55, 32'h0F0F0F0F, 8'h55);
        vcnt  = 0;
        rises = 0;
        prev  = 1'b0;
        fork
            begin
                send(32'h01020304, 1'b0);
                send(32'hA0B0C0D0, 1'b1);
                send(32'h0F0F0F0F, 1'b0);
            end
            begin
                repeat (30) begin
                    @(negedge CLK);
                    if (TX_VALID) vcnt++;
                    if (TX_VALID && !prev) rises++;
                    prev = TX_VALID;
                end
            end
        join
        chk("b2b_bytes", vcnt,  c_B2B_BYTES);
        chk("b2b_gaps",  rises, 1);
        wait_drain("b2b");

        // Reset two bytes into a frame with two results queued
        r_exp_q.push_back(8'h55);
        r_exp_q.push_back(8'h11);
        send(32'h11223344, 1'b0);
        send(32'h55667788, 1'b0);
        send(32'h99AABBCC, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_valid", TX_VALID, 0);
        chk("mid_rst_busy",  Busy,     0);
        chk("mid_rst_data",  TX_DATA,  0);
        chk("mid_rst_drop",  Drop_ERR, 0);
        chk("mid_rst_sb",    r_exp_q.size(), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (TX_VALID) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        chk("post_rst_busy",  Busy, 0);

        // Carry set after reset recovery
        push_frame(8'hD5, 32'hFFFF0001, 8'hD4);
        send(32'hFFFF0001, 1'b1);
        @(posedge CLK);
        #1;
        chk("carry_hdr", TX_DATA, 8'hD5);
        wait_drain("carry");

        chk("sb_empty", r_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
